mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RAM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, RAM word-address width (64 words).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, listed first:
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  async active-low reset
REQ-004 SHALL have these core-side ports:
- i_req  in  1  access request, sampled only in IDLE
- i_we  in  1  1=store, 0=load
- i_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- i_unsigned  in  1  zero-extend loads (lbu/lhu)
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-aligned
- o_busy  out  1  request in progress
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  32  load result, held until next load completes
- o_misaligned  out  1  error flag, valid with o_done
REQ-005 SHALL have these RAM-side ports:
- o_ram_addr  out  ADDR_WIDTH  word address
- o_ram_data  out  DATA_WIDTH  write word
- o_ram_we  out  1  write enable
- i_ram_data  in  DATA_WIDTH  combinational read word; RAM returns 0 while we=1

Function
REQ-006 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-007 SHALL register i_we, i_size, i_unsigned, i_addr and i_wdata in IDLE when i_req=1, and assert o_busy from the next cycle until DONE is left.
REQ-008 SHALL ignore i_req while o_busy=1 or o_done=1.
REQ-009 SHALL flag as misaligned: half with addr[0]=1, word with addr[1:0]!=0, and size=11. A flagged request goes IDLE->DONE with o_misaligned=1, performs no RAM access and leaves o_rdata unchanged.
REQ-010 SHALL drive o_ram_addr = captured addr[ADDR_WIDTH+1:2]. Upper address bits SHALL be ignored, so addresses wrap modulo 256 bytes.
REQ-011 SHALL use little-endian lanes: byte n = bits 8n+7:8n, with n = addr[1:0]; half at addr[1]=1 = bits 31:16.
REQ-012 SHALL run loads as IDLE->READ->DONE. In READ, o_ram_we=0; the lane is extracted from i_ram_data and sign- or zero-extended per i_unsigned, then registered into o_rdata at the end of READ.
REQ-013 SHALL run word stores as IDLE->WRITE->DONE, with o_ram_we=1 and o_ram_data=i_wdata for exactly one cycle.
REQ-014 SHALL run byte/half stores as read-modify-write: IDLE->READ->WRITE->DONE. The word is captured in READ; WRITE drives it with only the addressed lane replaced by i_wdata[7:0] or [15:0].
REQ-015 SHALL assert o_done for exactly one cycle in DONE, then return to IDLE. Latency from the i_req sample edge to o_done high: load 2 cycles, sw 2, sb/sh 3, misaligned 1.
REQ-016 SHALL drive o_ram_we only from the state register (=1 only in WRITE), never combinationally from inputs.
REQ-017 SHALL clear o_misaligned on the next accepted request.

Reset
REQ-018 While i_rst_n=0, the block SHALL immediately force: state=IDLE, o_busy=0, o_done=0, o_misaligned=0, o_rdata=0, o_ram_we=0, o_ram_addr=0, o_ram_data=0.
REQ-019 Reset during READ or WRITE SHALL abort the access with no write issued after reset is asserted. The first request after deassertion SHALL be accepted normally.

Structure
REQ-020 Size codes, FSM state encoding and DATA_WIDTH/ADDR_WIDTH defaults SHALL live in shared package mem_access_pkg.
REQ-021 Lane extraction/extension and lane merge SHALL be one combinational sub-module, mem_lane_align. The FSM and registers SHALL stay in mem_access_unit.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- sw addr=0x8, wdata=0xDEADBEEF; then lw addr=0x8 -> one write to word 2; o_rdata=0xDEADBEEF with o_done 2 cycles after each request.
- word 2=0xDEADBEEF; lb addr=0xB -> o_rdata=0xFFFFFFDE; lbu addr=0xB -> 0x000000DE; lh addr=0xA -> 0xFFFFDEAD.
- word 2=0xDEADBEEF; sb addr=0x9, wdata=0x55 -> READ then one WRITE of 0xDEAD55EF; o_done 3 cycles after request.
- lw addr=0x6 -> o_done with o_misaligned=1 after 1 cycle, o_ram_we never high, o_rdata unchanged.
- i_req held high during an sh -> exactly one access; next request accepted only after o_done.
- i_rst_n low during WRITE of sb -> o_ram_we drops immediately, all outputs 0; sw addr=0x100 after reset writes word 0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the byte-addressable memory access unit:
// access size codes, FSM state encoding and default geometry.
package mem_access_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int LANES          = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Reserved size code is treated as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return offset[0];
            SIZE_WORD: return (offset != 2'b00);
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane logic: extracts and extends a load lane from a RAM word,
// and merges store data into the addressed lane(s) of a RAM word.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [1:0]            i_offset,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_load,
    output logic [DATA_WIDTH-1:0] o_merged
);

    logic [DATA_WIDTH-1:0] w_shifted;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    assign w_shifted = i_word >> {i_offset, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];

    always_comb begin
        o_load = '0;
        case (i_size)
            SIZE_BYTE: o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SIZE_HALF: o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
            default:   o_load = i_word[31:0];
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       w_hit;
            logic [7:0] w_lane_new;

            // A half store feeds its low byte to even lanes, high byte to odd lanes.
            always_comb begin
                w_hit      = 1'b0;
                w_lane_new = i_wdata[8*gi +: 8];
                case (i_size)
                    SIZE_BYTE: begin
                        w_hit      = (i_offset == LANE);
                        w_lane_new = i_wdata[7:0];
                    end
                    SIZE_HALF: begin
                        w_hit      = (i_offset[1] == LANE[1]);
                        w_lane_new = i_wdata[8*(gi%2) +: 8];
                    end
                    SIZE_WORD: w_hit = 1'b1;
                    default:   w_hit = 1'b0;
                endcase
            end

            assign o_merged[8*gi +: 8] = w_hit ? w_lane_new : i_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a core and a single-port word RAM: byte/half/word
// accesses, sign/zero extension, read-modify-write for sub-word stores.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [31:0]           o_rdata,
    output logic                  o_misaligned,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_we,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);

    state_e                r_state;
    logic                  r_we;
    logic                  r_unsigned;
    logic [1:0]            r_size;
    logic [1:0]            r_offset;
    logic [31:0]           r_wdata;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_misaligned;
    logic [31:0]           r_rdata;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_data;

    logic [31:0]           w_load;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_misaligned;
    logic                  w_unused_addr;

    // Address bits above the RAM window are dropped, so accesses wrap.
    assign w_unused_addr = ^i_addr[31:ADDR_WIDTH+2];
    assign w_misaligned  = is_misaligned(i_size, i_addr[1:0]);

    mem_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_align (
        .i_word    (i_ram_data),
        .i_size    (r_size),
        .i_unsigned(r_unsigned),
        .i_offset  (r_offset),
        .i_wdata   (r_wdata),
        .o_load    (w_load),
        .o_merged  (w_merged)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= 2'b00;
            r_offset     <= 2'b00;
            r_wdata      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_rdata      <= '0;
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_we         <= i_we;
                        r_size       <= i_size;
                        r_unsigned   <= i_unsigned;
                        r_offset     <= i_addr[1:0];
                        r_wdata      <= i_wdata;
                        r_ram_addr   <= i_addr[ADDR_WIDTH+1:2];
                        r_busy       <= 1'b1;
                        r_misaligned <= w_misaligned;
                        if (w_misaligned) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (i_we && (i_size == SIZE_WORD)) begin
                            r_state    <= ST_WRITE;
                            r_ram_data <= i_wdata;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                // Sub-word stores capture the merged word here; loads latch the result.
                ST_READ: begin
                    if (r_we) begin
                        r_ram_data <= w_merged;
                        r_state    <= ST_WRITE;
                    end else begin
                        r_rdata <= w_load;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_rdata      = r_rdata;
    assign o_misaligned = r_misaligned;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_data   = r_ram_data;
    assign o_ram_we     = (r_state == ST_WRITE);

endmodule
